pad_input_conditioner: RTL and testbench

//   Per-pad input conditioning for the pulpemu GPIO path, directly downstream of the pad

---
 rtl/pad_input_conditioner.sv | 124 ++++++++++++
 tb/tb_pad_input_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pad_input_conditioner
// Description : Per-pad GPIO input conditioning. Each pad is resynchronised,
//               debounced against a shared stable-time threshold and run
//               through a configurable event detector that sets a sticky
//               interrupt status bit, cleared by software.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_input_conditioner #(
    parameter int NUM_PADS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_PADS-1:0]   pad_in_i,
    input  logic [DEBOUNCE_W-1:0] cfg_debounce_i,
    input  logic [NUM_PADS-1:0]   cfg_irq_en_i,
    input  logic [2*NUM_PADS-1:0] cfg_irq_type_i,
    input  logic [NUM_PADS-1:0]   irq_clear_i,
    output logic [NUM_PADS-1:0]   in_val_o,
    output logic [NUM_PADS-1:0]   irq_status_o,
    output logic                  irq_o
);

    localparam logic [DEBOUNCE_W-1:0] C_CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] C_TYPE_RISE  = 2'b00;
    localparam logic [1:0] C_TYPE_FALL  = 2'b01;
    localparam logic [1:0] C_TYPE_BOTH  = 2'b10;
    localparam logic [1:0] C_TYPE_LEVEL = 2'b11;

    logic [NUM_PADS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_PADS-1:0] w_sync_out;

    // Resynchronise all pad inputs into the clk_i domain
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= pad_in_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
            logic [DEBOUNCE_W-1:0] r_cnt;
            logic                  r_val;
            logic                  r_prev;
            logic                  r_status;
            logic                  w_rise;
            logic                  w_fall;
            logic                  w_event;

            // Debounce: accept the synchronised level once it has disagreed
            // with the filtered value for more than T consecutive edges.
            // The >= compare lets a lowered threshold act immediately and
            // keeps the counter from ever passing T, so it cannot wrap.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                    r_val <= 1'b0;
                end else if (w_sync_out[i] == r_val) begin
                    r_cnt <= '0;
                end else if (r_cnt >= cfg_debounce_i) begin
                    r_val <= w_sync_out[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end

            // Delayed copy of the filtered value for edge detection
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= r_val;
                end
            end

            assign w_rise = r_val & ~r_prev;
            assign w_fall = ~r_val & r_prev;

            // Select the event condition for this pad's configured type
            always_comb begin
                w_event = 1'b0;
                case (cfg_irq_type_i[2*i +: 2])
                    C_TYPE_RISE:  w_event = w_rise;
                    C_TYPE_FALL:  w_event = w_fall;
                    C_TYPE_BOTH:  w_event = w_rise | w_fall;
                    C_TYPE_LEVEL: w_event = r_val;
                    default:      w_event = 1'b0;
                endcase
            end

            // Sticky status: an enabled event sets it and beats a clear
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_status <= 1'b0;
                end else if (w_event && cfg_irq_en_i[i]) begin
                    r_status <= 1'b1;
                end else if (irq_clear_i[i]) begin
                    r_status <= 1'b0;
                end
            end

            assign in_val_o[i]     = r_val;
            assign irq_status_o[i] = r_status;
        end
    endgenerate

    assign irq_o = |irq_status_o;

endmodule
`default_nettype wire

// File: tb/tb_pad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_input_conditioner
// Description : Self-checking bench for pad_input_conditioner: directed
//               scenarios followed by randomized traffic, all compared
//               against a behavioural reference model each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_input_conditioner;

    localparam int N = 32;
    localparam int S = 2;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   pad_in;
    logic [W-1:0]   cfg_t;
    logic [N-1:0]   cfg_en;
    logic [2*N-1:0] cfg_type;
    logic [N-1:0]   clr;
    logic [N-1:0]   in_val;
    logic [N-1:0]   irq_status;
    logic           irq;

    pad_input_conditioner #(
        .NUM_PADS    (N),
        .SYNC_STAGES (S),
        .DEBOUNCE_W  (W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .pad_in_i       (pad_in),
        .cfg_debounce_i (cfg_t),
        .cfg_irq_en_i   (cfg_en),
        .cfg_irq_type_i (cfg_type),
        .irq_clear_i    (clr),
        .in_val_o       (in_val),
        .irq_status_o   (irq_status),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    // Reference model: the synchroniser is a pure delay of S samples, the
    // debouncer tracks how long the delayed input has disagreed with the
    // accepted value, and events are derived from the accepted history.
    logic [N-1:0] m_hist[$];
    int           m_run [N];
    logic [N-1:0] m_val;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_stat;

    int vectors;
    int miscompares;

    task automatic model_edge();
        logic [N-1:0] delayed;
        logic [N-1:0] nval;
        logic         ev;
        if (!rst_ni) begin
            m_hist.delete();
            for (int k = 0; k < S; k++) m_hist.push_back('0);
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_val  = '0;
            m_prev = '0;
            m_stat = '0;
            return;
        end
        delayed = m_hist.pop_front();
        m_hist.push_back(pad_in);
        nval = m_val;
        for (int i = 0; i < N; i++) begin
            if (delayed[i] == m_val[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] >= int'(cfg_t)) begin
                nval[i]  = delayed[i];
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
            end
            case (cfg_type[2*i +: 2])
                2'b00:   ev = m_val[i] && !m_prev[i];
                2'b01:   ev = !m_val[i] && m_prev[i];
                2'b10:   ev = m_val[i] != m_prev[i];
                default: ev = m_val[i];
            endcase
            if (ev && cfg_en[i]) m_stat[i] = 1'b1;
            else if (clr[i])     m_stat[i] = 1'b0;
        end
        m_prev = m_val;
        m_val  = nval;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, compare all outputs, drop the clear pulse
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("in_val", in_val, m_val);
        check("irq_status", irq_status, m_stat);
        check("irq_o", {{(N-1){1'b0}}, irq}, {{(N-1){1'b0}}, |m_stat});
        clr = '0;
    endtask

    task automatic wait_rise(input string tag, input int pad, input int exp_edges);
        int n;
        n = 0;
        while (n < 400) begin
            step();
            n++;
            if (in_val[pad] === 1'b1) break;
        end
        check_int(tag, n, exp_edges);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni   = 1'b0;
        pad_in   = '1;
        cfg_t    = '0;
        cfg_en   = '0;
        cfg_type = '0;
        clr      = '0;

        // Reset with all pads high: outputs stay cleared
        repeat (3) step();
        check("reset_val", in_val, '0);
        check("reset_stat", irq_status, '0);
        rst_ni = 1'b1;
        wait_rise("post_reset_latency", 0, S + 0 + 1);

        // Debounce latency with T=4 and T=0
        pad_in = '0;
        cfg_t  = 8'd4;
        repeat (12) step();
        pad_in[3] = 1'b1;
        wait_rise("latency_t4", 3, 7);
        pad_in[3] = 1'b0;
        repeat (12) step();
        cfg_t = 8'd0;
        pad_in[3] = 1'b1;
        wait_rise("latency_t0", 3, 3);
        pad_in[3] = 1'b0;
        repeat (6) step();

        // Glitch rejection: 3-cycle pulse filtered, 5-cycle pulse accepted
        cfg_t = 8'd4;
        pad_in[3] = 1'b1;
        repeat (3) step();
        pad_in[3] = 1'b0;
        repeat (10) step();
        check("glitch3_val", {31'b0, in_val[3]}, 32'h0);
        pad_in[3] = 1'b1;
        repeat (5) step();
        pad_in[3] = 1'b0;
        repeat (2) step();
        check("pulse5_val", {31'b0, in_val[3]}, 32'h1);
        repeat (12) step();

        // Edge types: pad5 rise, pad6 fall, pad7 both
        cfg_t = 8'd0;
        cfg_type[11:10] = 2'b00;
        cfg_type[13:12] = 2'b01;
        cfg_type[15:14] = 2'b10;
        cfg_en[7:5] = 3'b111;
        pad_in[7:5] = 3'b111;
        repeat (6) step();
        check("edge_rise", {29'b0, irq_status[7:5]}, 32'h5);
        clr[7:5] = 3'b111;
        repeat (2) step();
        check("edge_clear", {29'b0, irq_status[7:5]}, 32'h0);
        pad_in[7:5] = 3'b000;
        repeat (6) step();
        check("edge_fall", {29'b0, irq_status[7:5]}, 32'h6);
        clr[7:5] = 3'b111;
        step();

        // Set beats simultaneous clear; later clear alone works; level persists
        cfg_type[5:4] = 2'b00;
        cfg_en[2] = 1'b1;
        pad_in[2] = 1'b1;
        repeat (3) step();
        clr[2] = 1'b1;
        step();
        check("set_wins", {31'b0, irq_status[2]}, 32'h1);
        clr[2] = 1'b1;
        step();
        check("clear_alone", {31'b0, irq_status[2]}, 32'h0);
        cfg_type[5:4] = 2'b11;
        step();
        clr[2] = 1'b1;
        step();
        check("level_sticky", {31'b0, irq_status[2]}, 32'h1);
        pad_in[2] = 1'b0;
        repeat (5) step();
        clr[2] = 1'b1;
        step();
        check("level_released", {31'b0, irq_status[2]}, 32'h0);

        // Disabled pad still filters but never sets status
        cfg_type[19:18] = 2'b10;
        cfg_en[9] = 1'b0;
        pad_in[9] = 1'b1;
        repeat (5) step();
        check("dis_val", {31'b0, in_val[9]}, 32'h1);
        pad_in[9] = 1'b0;
        repeat (5) step();
        check("dis_stat", {31'b0, irq_status[9]}, 32'h0);

        // Lowering T mid-count takes effect on the next edge
        cfg_t = 8'd200;
        pad_in[10] = 1'b1;
        repeat (102) step();
        check("t_high_hold", {31'b0, in_val[10]}, 32'h0);
        cfg_t = 8'd3;
        step();
        check("t_drop", {31'b0, in_val[10]}, 32'h1);
        pad_in[10] = 1'b0;
        repeat (10) step();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            pad_in = pad_in ^ ($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) cfg_t = W'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) cfg_type = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) cfg_en = $urandom;
            clr    = $urandom & $urandom;
            rst_ni = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute watchdog in case a step never completes
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
